// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: detect-mode selectors
// and the legal range of the pattern length.
package seq_det_pkg;

    localparam int MODE_MEALY = 0;
    localparam int MODE_MOORE = 1;

    localparam int LEN_MIN = 2;
    localparam int LEN_MAX = 16;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with a registered "all ones" flag.
// The flag is computed from the next count, so it is exactly in step with cnt.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_r;
    logic         sat_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: step by one unless already pinned at all-ones
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (inc && !sat_r) begin
            cnt_nxt_s = cnt_r + W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and saturation flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            sat_r <= &cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign sat = sat_r;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector.
// Bits arrive MSB-first on j (qualified by en) and are compared against a
// loadable pattern. A fill counter guarantees that only bits received since
// the last reset/load (or, without overlap, since the last match) can form
// a match. Detect is either combinational (Mealy) or registered (Moore).
import seq_det_pkg::*;

module seq_detector_param #(
    parameter int LEN     = 4,
    parameter int MOORE   = 0,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             j,
    input  logic             load,
    input  logic [LEN-1:0]   pat,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // Fill counts 0..LEN inclusive
    localparam int FW = $clog2(LEN + 1);

    logic [LEN-1:0] hist_r;
    logic [FW-1:0]  fill_r;
    logic [LEN-1:0] pat_r;
    logic [LEN-1:0] window_s;
    logic           match_s;

    // Candidate window and match decision; load always suppresses a match
    always_comb begin
        window_s = {hist_r[LEN-2:0], j};
        match_s  = 1'b0;
        if (en && !load && (fill_r >= FW'(LEN - 1)) && (window_s == pat_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // History, fill and pattern registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= '0;
            fill_r <= '0;
            pat_r  <= {LEN{1'b1}};
        end else if (load) begin
            // New pattern: forget partial progress, ignore this cycle's bit
            pat_r  <= pat;
            fill_r <= '0;
        end else if (en) begin
            hist_r <= window_s;
            if (match_s && (OVERLAP == 0)) begin
                // Non-overlapping: the matched bits are consumed
                fill_r <= '0;
            end else if (fill_r != FW'(LEN)) begin
                fill_r <= fill_r + FW'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    generate
        if (MOORE == MODE_MOORE) begin : g_moore
            logic detect_r;

            // Registered detect: one-cycle pulse the cycle after the final bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    detect_r <= 1'b0;
                end else begin
                    detect_r <= match_s;
                end
            end

            assign detect = detect_r;
        end else begin : g_mealy
            // Combinational detect, forced low during reset
            assign detect = match_s & ~rst;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match_s),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four instances sharing one input stream
//   A: Mealy, overlap,     CNT_W=8
//   B: Mealy, no overlap,  CNT_W=8
//   C: Moore, overlap,     CNT_W=8
//   D: Mealy, overlap,     CNT_W=2 (saturation)
// The reference model keeps the list of all accepted bits and, per instance,
// the index where counting restarted; a match is a lookup on that list.
module tb_seq_detector_param;

    localparam int LEN = 4;

    typedef struct packed {
        logic       rst;
        logic [3:0] det;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [1:0] c3;
        logic [3:0] sat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       j;
    logic       load;
    logic [3:0] pat;

    logic       det_a, det_b, det_c, det_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;
    logic       sat_a, sat_b, sat_c, sat_d;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // reference model state
    bit         stream [8192];
    int         slen = 0;
    int         clr [4];
    int         cnt_m [4];
    int         maxv [4];
    logic [3:0] patv;
    bit         prev_c;

    seq_detector_param #(.LEN(LEN), .MOORE(0), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .j(j), .load(load), .pat(pat),
        .detect(det_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
    seq_detector_param #(.LEN(LEN), .MOORE(0), .OVERLAP(0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .j(j), .load(load), .pat(pat),
        .detect(det_b), .match_cnt(cnt_b), .cnt_sat(sat_b));
    seq_detector_param #(.LEN(LEN), .MOORE(1), .OVERLAP(1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .en(en), .j(j), .load(load), .pat(pat),
        .detect(det_c), .match_cnt(cnt_c), .cnt_sat(sat_c));
    seq_detector_param #(.LEN(LEN), .MOORE(0), .OVERLAP(1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .en(en), .j(j), .load(load), .pat(pat),
        .detect(det_d), .match_cnt(cnt_d), .cnt_sat(sat_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // monitor: pop the expectation for this cycle and compare mid-cycle
    logic a_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("det_a", int'(det_a), int'(e.det[0]));
            chk("det_b", int'(det_b), int'(e.det[1]));
            chk("det_c", int'(det_c), int'(e.det[2]));
            chk("det_d", int'(det_d), int'(e.det[3]));
            chk("cnt_a", int'(cnt_a), int'(e.c0));
            chk("cnt_b", int'(cnt_b), int'(e.c1));
            chk("cnt_c", int'(cnt_c), int'(e.c2));
            chk("cnt_d", int'(cnt_d), int'(e.c3));
            chk("sat_a", int'(sat_a), int'(e.sat[0]));
            chk("sat_b", int'(sat_b), int'(e.sat[1]));
            chk("sat_c", int'(sat_c), int'(e.sat[2]));
            chk("sat_d", int'(sat_d), int'(e.sat[3]));
            if (!e.rst) begin
                chk("moore_vs_mealy_delayed", int'(det_c ^ a_prev), 0);
            end
        end
        a_prev = det_a;
    end

    // one clock of stimulus; expectation pushed, then model advanced
    task automatic step(input bit r, input bit e, input bit b, input bit l,
                        input logic [3:0] p);
        exp_t x;
        bit   m [4];
        int   val;
        @(posedge clk);
        #1;
        rst = r; en = e; j = b; load = l; pat = p;
        for (int i = 0; i < 4; i++) begin
            m[i] = 1'b0;
            if (!r && e && !l && (slen - clr[i] >= LEN - 1)) begin
                val = 0;
                for (int k = slen - (LEN - 1); k < slen; k++) val = (val << 1) | int'(stream[k]);
                val = (val << 1) | int'(b);
                m[i] = (val == int'(patv));
            end
        end
        x.rst = r;
        if (r) begin
            x.det = 4'b0000; x.c0 = 8'd0; x.c1 = 8'd0; x.c2 = 8'd0; x.c3 = 2'd0; x.sat = 4'b0000;
        end else begin
            x.det = {m[3], prev_c, m[1], m[0]};
            x.c0 = 8'(cnt_m[0]); x.c1 = 8'(cnt_m[1]); x.c2 = 8'(cnt_m[2]); x.c3 = 2'(cnt_m[3]);
            for (int i = 0; i < 4; i++) x.sat[i] = (cnt_m[i] == maxv[i]);
        end
        sb.push_back(x);
        // effect of the coming clock edge
        if (r) begin
            for (int i = 0; i < 4; i++) begin clr[i] = slen; cnt_m[i] = 0; end
            patv   = 4'b1111;
            prev_c = 1'b0;
        end else begin
            prev_c = m[2];
            if (l) begin
                patv = p;
                for (int i = 0; i < 4; i++) clr[i] = slen;
            end else if (e) begin
                stream[slen] = b;
                slen++;
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) begin
                        if (cnt_m[i] < maxv[i]) cnt_m[i]++;
                        if (i == 1) clr[i] = slen;
                    end
                end
            end
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, v[k], 1'b0, 4'b0000);
    endtask

    task automatic do_load(input logic [3:0] p);
        step(1'b0, 1'b0, 1'b0, 1'b1, p);
    endtask

    initial begin
        maxv[0] = 255; maxv[1] = 255; maxv[2] = 255; maxv[3] = 3;
        for (int i = 0; i < 4; i++) begin clr[i] = 0; cnt_m[i] = 0; end
        patv = 4'b1111; prev_c = 1'b0;
        rst = 1'b1; en = 1'b0; j = 1'b0; load = 1'b0; pat = 4'b0000;

        // reset state, with en/j active to prove Mealy detect is masked
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);

        // overlap / non-overlap / Moore on 1,0,0,1,0,0,1
        do_load(4'b1001);
        send_bits(16'b1001001, 7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // en gap in the middle of a pattern
        do_load(4'b1001);
        send_bits(16'b10, 2);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, k[0], 1'b0, 4'b0000);
        send_bits(16'b01, 2);

        // reset discards partial bits
        send_bits(16'b100, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        do_load(4'b1001);
        send_bits(16'b1, 1);
        // load mid-stream, then exactly one match of the new pattern
        send_bits(16'b10, 2);
        do_load(4'b0110);
        send_bits(16'b0110, 4);

        // load collides with a would-be match: load wins
        do_load(4'b1001);
        send_bits(16'b100, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001);

        // saturation of the 2-bit counter: five overlapping matches
        send_bits(16'b1001001001001001, 16);

        // all-ones default pattern after reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        send_bits(16'b111111, 6);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int  rr;
            bit  r, e, l;
            rr = int'($urandom_range(999, 0));
            r  = (rr < 8);
            l  = (rr >= 8 && rr < 30);
            e  = ($urandom_range(9, 0) < 7);
            step(r, e, 1'($urandom_range(1, 0)), l, 4'($urandom_range(15, 0)));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        // drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_detector_param
